// File: rtl/ram_banked_pkg.sv
// Shared definitions for the banked RAM: default geometry and sequencer state encoding.
// Read style of the RAM is selected by the RAM_BANKED_SYNC_READ_EN macro.
package ram_pkg;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_ADDR_BITS = 6;
  localparam int DEF_BANK_BITS = 3;

  function automatic int pow2(input int bits);
    return 1 << bits;
  endfunction

  localparam int DEPTH      = pow2(DEF_ADDR_BITS);
  localparam int NBANKS     = pow2(DEF_BANK_BITS);
  localparam int BANK_DEPTH = pow2(DEF_ADDR_BITS - DEF_BANK_BITS);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/ram_bank.sv
// One storage bank. Combinational read by default; with RAM_BANKED_SYNC_READ_EN
// the read is registered with write-first bypass so it maps onto block RAM.
module ram_bank #(
  parameter int WIDTH    = 16,
  parameter int OFF_BITS = 3
) (
  input  logic                clk,
  input  logic [WIDTH-1:0]    in,
  input  logic [OFF_BITS-1:0] address,
  input  logic                load,
  output logic [WIDTH-1:0]    out
);
  logic [WIDTH-1:0] mem [2**OFF_BITS];

  always_ff @(posedge clk) begin
    if (load) mem[address] <= in;
  end

`ifdef RAM_BANKED_SYNC_READ_EN
  always_ff @(posedge clk) begin
    out <= load ? in : mem[address];
  end
`else
  assign out = mem[address];
`endif
endmodule

// File: rtl/ram_banked.sv
// Parametrised banked RAM with a zero-fill sequencer (busy while clearing).
// RAM_BANKED_SYNC_READ_EN selects a registered 1-cycle read; default is combinational.
module ram_banked
  import ram_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int ADDR_BITS      = DEF_ADDR_BITS,
  parameter int BANK_BITS      = DEF_BANK_BITS,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 load,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic                 busy
);
  localparam int OFF_BITS = ADDR_BITS - BANK_BITS;
  localparam int N_BANKS  = pow2(BANK_BITS);
  localparam logic [ADDR_BITS-1:0] LAST = '1;

  state_t               state, state_n;
  logic [ADDR_BITS-1:0] clr_addr, clr_addr_n;

  logic [ADDR_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic                 wr_en;
  logic [BANK_BITS-1:0] bank_sel;
  logic [OFF_BITS-1:0]  bank_off;
  logic [N_BANKS-1:0][WIDTH-1:0] bank_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_addr <= '0;
    end else begin
      state    <= state_n;
      clr_addr <= clr_addr_n;
    end
  end

  always_comb begin
    state_n    = state;
    clr_addr_n = clr_addr;
    case (state)
      IDLE: begin
        if (clear) begin
          state_n    = CLEAR;
          clr_addr_n = '0;
        end
      end
      CLEAR: begin
        if (clr_addr == LAST) begin
          state_n    = IDLE;
          clr_addr_n = '0;
        end else begin
          clr_addr_n = clr_addr + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Sequencer owns the write port while clearing; nothing is written on a reset edge.
  always_comb begin
    busy    = (state == CLEAR);
    wr_addr = busy ? clr_addr : address;
    wr_data = busy ? '0 : in;
    wr_en   = !reset && (busy || load);
  end

  assign bank_sel = wr_addr[ADDR_BITS-1 -: BANK_BITS];
  assign bank_off = wr_addr[OFF_BITS-1:0];

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    ram_bank #(
      .WIDTH    (WIDTH),
      .OFF_BITS (OFF_BITS)
    ) u_bank (
      .clk     (clk),
      .in      (wr_data),
      .address (bank_off),
      .load    (wr_en && (bank_sel == BANK_BITS'(b))),
      .out     (bank_out[b])
    );
  end

`ifdef RAM_BANKED_SYNC_READ_EN
  // rd_ok marks a read captured in IDLE that will not be overtaken by a clear.
  logic                 rd_ok;
  logic [BANK_BITS-1:0] rd_bank;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ok   <= 1'b0;
      rd_bank <= '0;
    end else begin
      rd_ok   <= (state == IDLE) && !clear;
      rd_bank <= bank_sel;
    end
  end

  assign out = rd_ok ? bank_out[rd_bank] : '0;
`else
  assign out = busy ? '0 : bank_out[bank_sel];
`endif
endmodule

// File: tb/tb_ram_banked.sv
// Self-checking bench for ram_banked: directed vector table, clear/reset sequences,
// random traffic against an array model, and a wide/deep parameter instance.
module tb_ram_banked;
  localparam int D = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, load, clear, busy;
  logic [15:0] in, out;
  logic [5:0]  address;

  logic        r1, l1, c1, b1;
  logic [7:0]  i1, o1;
  logic [9:0]  a1;

  ram_banked dut0 (
    .clk(clk), .reset(reset), .in(in), .address(address),
    .load(load), .clear(clear), .out(out), .busy(busy)
  );

  ram_banked #(.WIDTH(8), .ADDR_BITS(10), .BANK_BITS(2)) dut1 (
    .clk(clk), .reset(r1), .in(i1), .address(a1),
    .load(l1), .clear(c1), .out(o1), .busy(b1)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] mem_m [D];
  int          busy_cnt;
  logic [15:0] exp_out;

  typedef struct {
    logic        ld;
    logic [5:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: a clear is DEPTH remaining zero-writes in address order.
  task automatic model_edge();
`ifdef RAM_BANKED_SYNC_READ_EN
    logic [15:0] nxt;
    if (reset || busy_cnt > 0 || clear) nxt = '0;
    else nxt = load ? in : mem_m[address];
    exp_out = nxt;
`endif
    if (reset) busy_cnt = D;
    else if (busy_cnt > 0) begin
      mem_m[D - busy_cnt] = '0;
      busy_cnt--;
    end else begin
      if (load) mem_m[address] = in;
      if (clear) busy_cnt = D;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
`ifndef RAM_BANKED_SYNC_READ_EN
    exp_out = (busy_cnt > 0) ? 16'h0 : mem_m[address];
`endif
    chk("busy", busy, busy_cnt > 0);
    chk("out", out, exp_out);
  endtask

  task automatic count_busy(input string nm, input int want);
    int nb;
    nb = (busy === 1'b1) ? 1 : 0;
    for (int g = 0; g < 200 && busy === 1'b1; g++) begin
      tick();
      if (busy === 1'b1) nb++;
    end
    load = 1'b0;
    chk(nm, nb, want);
  endtask

  vec_t tbl [8];

  initial begin
    tbl = '{
      '{1'b1, 6'd0,  16'h1234, 16'h0000},
      '{1'b1, 6'd63, 16'hABCD, 16'h0000},
      '{1'b1, 6'd8,  16'h5A5A, 16'h0000},
      '{1'b0, 6'd0,  16'h0000, 16'h1234},
      '{1'b0, 6'd63, 16'h0000, 16'hABCD},
      '{1'b0, 6'd8,  16'h0000, 16'h5A5A},
      '{1'b0, 6'd7,  16'h0000, 16'h0000},
      '{1'b0, 6'd9,  16'h0000, 16'h0000}
    };
    for (int i = 0; i < D; i++) mem_m[i] = '0;
    busy_cnt = 0; exp_out = '0;
    reset = 1'b1; load = 1'b0; clear = 1'b0; address = '0; in = '0;
    r1 = 1'b1; l1 = 1'b0; c1 = 1'b0; a1 = '0; i1 = '0;

    @(negedge clk);
    tick();
    chk("reset_busy", busy, 1'b1);
    chk("reset_out", out, 16'h0);
    reset = 1'b0; r1 = 1'b0;

    // Load during the reset clear must be dropped.
    load = 1'b1; address = 6'd5; in = 16'hBEEF;
    count_busy("reset_busy_len", 64);
    address = 6'd5;
    tick();
    chk("mem5_dropped", out, 16'h0);
    for (int a = 0; a < D; a++) begin
      address = 6'(a);
      tick();
    end

    foreach (tbl[i]) begin
      load = tbl[i].ld; address = tbl[i].a; in = tbl[i].d;
      tick();
      if (!tbl[i].ld) chk("tbl_read", out, tbl[i].exp);
    end
    load = 1'b0;

    clear = 1'b1;
    tick();
    clear = 1'b0;
    count_busy("clear_busy_len", 64);
    address = 6'd0;  tick(); chk("clr_a0", out, 16'h0);
    address = 6'd63; tick(); chk("clr_a63", out, 16'h0);
    address = 6'd8;  tick(); chk("clr_a8", out, 16'h0);

    // Write then clear in the same cycle: net result zero.
    address = 6'd20; in = 16'h7777; load = 1'b1; clear = 1'b1;
    tick();
    load = 1'b0; clear = 1'b0;
    count_busy("ldclr_busy_len", 64);
    address = 6'd20; tick(); chk("ldclr_a20", out, 16'h0);

    // Reset at cycle 30 of a clear restarts the full sequence.
    address = 6'd11; in = 16'h1111; load = 1'b1; tick(); load = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (29) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    count_busy("midreset_busy_len", 64);

    // Write visible the cycle after the edge (registered read: via bypass).
    load = 1'b1; address = 6'd3; in = 16'h0F0F;
    tick();
    chk("wr_visible", out, 16'h0F0F);
    load = 1'b0; address = 6'd4;
    tick();
    chk("addr4", out, mem_m[4]);

    for (int k = 0; k < 500; k++) begin
      load = 1'($urandom_range(0, 1)); address = 6'($urandom);
      in = 16'($urandom);
      clear = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    load = 1'b0; clear = 1'b0; reset = 1'b0;
    for (int g = 0; g < 200 && busy_cnt > 0; g++) tick();
    for (int a = 0; a < D; a++) begin
      address = 6'(a);
      tick();
    end

    // Wide/deep instance.
    for (int g = 0; g < 3000 && b1 !== 1'b0; g++) @(negedge clk);
    chk("d1_idle", b1, 1'b0);
    l1 = 1'b1; a1 = 10'd1023; i1 = 8'hFF; @(negedge clk);
    a1 = 10'd0; i1 = 8'h01; @(negedge clk);
    l1 = 1'b0; a1 = 10'd1023; @(negedge clk);
    chk("d1_a1023", o1, 8'hFF);
    a1 = 10'd0; @(negedge clk);
    chk("d1_a0", o1, 8'h01);
    c1 = 1'b1; @(negedge clk); c1 = 1'b0;
    begin
      int nb;
      nb = 0;
      for (int g = 0; g < 3000 && b1 === 1'b1; g++) begin
        nb++;
        @(negedge clk);
      end
      chk("d1_busy_len", nb, 1024);
    end
    a1 = 10'd1023; @(negedge clk);
    chk("d1_clr_a1023", o1, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_banked.md
Name: ram_banked

Overview:
- Parametrised successor to the fixed 64-word banked RAM built from RAM8 banks.
- Configurable word width, depth and bank count. Address high bits select the bank; low bits select the word within the bank.
- Adds a hardware clear sequencer that zero-fills every word after reset or on request, with a busy flag.
- Drop-in data memory for the Hack CPU and the screen/scratch RAMs. With default parameters it is functionally equivalent to the existing 64-word RAM once clearing completes.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_BITS, 6, total address width; depth DEPTH = 2**ADDR_BITS.
- BANK_BITS, 3, number of address MSBs used as bank select; NBANKS = 2**BANK_BITS. Must satisfy 0 < BANK_BITS < ADDR_BITS.
- CLEAR_ON_RESET, 1, when 1 the reset starts a full clear; when 0 the reset only idles the sequencer.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  write data.
- address  input  ADDR_BITS  word address; bank = address[ADDR_BITS-1 -: BANK_BITS], offset = remaining low bits.
- load  input  1  write enable; writes in to address at the rising edge.
- clear  input  1  request a full zero-fill; sampled only in IDLE.
- out  output  WIDTH  read data for address.
- busy  output  1  high while the clear sequencer owns the memory.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Storage: NBANKS instances of ram_bank, each 2**(ADDR_BITS-BANK_BITS) words by WIDTH bits.
- Bank load is the demux of load by the bank field. out is the mux of the bank outputs by the bank field.
- Default read path (macro off): combinational. out = mem[address] in the same cycle. A write is visible the cycle after the edge (Hack RAM semantics).
- Sequencer states: IDLE and CLEAR. The clear pointer clr_addr is ADDR_BITS wide.
- Reset with CLEAR_ON_RESET=1: next state CLEAR, clr_addr=0, busy=1 in the following cycle.
- Reset with CLEAR_ON_RESET=0: next state IDLE, busy=0. Memory contents are untouched either way.
- IDLE: if clear=1, go to CLEAR with clr_addr=0. Otherwise perform normal load/read.
- CLEAR: every cycle write 0 to mem[clr_addr] and increment clr_addr.
  - When clr_addr == DEPTH-1, the write completes and the next state is IDLE.
  - A clear therefore takes exactly DEPTH cycles with busy=1.
- While busy=1:
  - load is ignored (dropped, not queued); clear is ignored.
  - out is forced to 0.
- Reset mid-clear restarts the clear at clr_addr=0 (if CLEAR_ON_RESET=1) or aborts to IDLE, leaving partial contents.
- Reset value of outputs: out=0 (forced while busy after reset), busy=1 if CLEAR_ON_RESET else 0. With CLEAR_ON_RESET=0, out after reset reflects existing contents.
- load=1 and clear=1 together in IDLE: the load write commits this edge and the clear starts next cycle. The net result is all zeros.
- Address wrap: none needed, because address width equals the full depth. clr_addr does not wrap past DEPTH-1.

Optional Feature:
- Macro RAM_BANKED_SYNC_READ_EN.
- Defined:
  - out is registered, with a 1-cycle read latency: out at edge n+1 = mem[address at edge n].
  - Write-first bypass: if load=1 to the same address in the same cycle, out gets in.
  - out register resets to 0 and holds 0 while busy.
  - This allows block-RAM inference.
- Undefined: combinational read, as described above.

Decomposition:
- Shared package ram_pkg: localparams for DEPTH, NBANKS and BANK_DEPTH derived from the parameters, and the state encoding (IDLE=1'b0, CLEAR=1'b1).
- One sub-module, ram_bank: a single bank with clk, in, address offset, load and out, with the read style selected by the same macro.
- Demux, mux and sequencer stay in ram_banked.

Test Plan:
- Reset with defaults → busy=1 for exactly 64 cycles, then 0; every address reads 0x0000; load during busy (addr 5, 0xBEEF) leaves mem[5]=0.
- In IDLE write 0x1234 to addr 0, 0xABCD to addr 63, 0x5A5A to addr 8 (bank 1 word 0) → reads return those values; addr 7 and addr 9 read 0.
- After the fills above, pulse clear → 64 busy cycles, out=0 throughout, then all three addresses read 0.
- Assert reset at cycle 30 of a clear → clear restarts; busy stays high for another 64 cycles after reset.
- Parameter sweep WIDTH=8, ADDR_BITS=10, BANK_BITS=2 → write addr 1023=0xFF, addr 0=0x01; readback is correct and the clear takes 1024 cycles.
- With RAM_BANKED_SYNC_READ_EN: write 0x0F0F to addr 3 with address=3 → out=0x0F0F next cycle (bypass); change address to 4 → out updates after one cycle.
